// File: rtl/memory_arbiter.sv
// Two-requester arbiter in front of one memory: independent write (aw/w) and read (ar/r) grant FSMs.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin priority; otherwise port 0 has fixed priority.
module memory_arbiter #(
    parameter int W = 16,
    parameter int D = 256,
    localparam int A = $clog2(D)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] s0_aw_data,
    input  logic         s0_aw_valid,
    output logic         s0_aw_ready,
    input  logic [W-1:0] s0_w_data,
    input  logic         s0_w_valid,
    output logic         s0_w_ready,
    input  logic [A-1:0] s0_ar_data,
    input  logic         s0_ar_valid,
    output logic         s0_ar_ready,
    output logic [W-1:0] s0_r_data,
    output logic         s0_r_valid,
    input  logic         s0_r_ready,
    input  logic [A-1:0] s1_aw_data,
    input  logic         s1_aw_valid,
    output logic         s1_aw_ready,
    input  logic [W-1:0] s1_w_data,
    input  logic         s1_w_valid,
    output logic         s1_w_ready,
    input  logic [A-1:0] s1_ar_data,
    input  logic         s1_ar_valid,
    output logic         s1_ar_ready,
    output logic [W-1:0] s1_r_data,
    output logic         s1_r_valid,
    input  logic         s1_r_ready,
    output logic [A-1:0] aw_data,
    output logic         aw_valid,
    input  logic         aw_ready,
    output logic [W-1:0] w_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [A-1:0] ar_data,
    output logic         ar_valid,
    input  logic         ar_ready,
    input  logic [W-1:0] r_data,
    input  logic         r_valid,
    output logic         r_ready
);
    typedef enum logic {WIDLE, WBUSY} wstate_t;
    typedef enum logic [1:0] {RIDLE, RADDR, RDATA} rstate_t;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;
    logic    wg_q, wg_d, rg_q, rg_d;
    logic    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic    wptr, rptr;
    logic    aw_hs, w_hs;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic wptr_q, wptr_d, rptr_q, rptr_d;
    assign wptr = wptr_q;
    assign rptr = rptr_q;
`else
    assign wptr = 1'b0;
    assign rptr = 1'b0;
`endif

    // Write path: aw and w may complete in either order; the grant holds until both have.
    always_comb begin
        wstate_d    = wstate_q;
        wg_d        = wg_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        wptr_d      = wptr_q;
`endif
        aw_valid    = 1'b0;
        aw_data     = '0;
        w_valid     = 1'b0;
        w_data      = '0;
        s0_aw_ready = 1'b0;
        s1_aw_ready = 1'b0;
        s0_w_ready  = 1'b0;
        s1_w_ready  = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        case (wstate_q)
            WIDLE: begin
                if (s0_aw_valid || s1_aw_valid) begin
                    wg_d     = (s0_aw_valid && s1_aw_valid) ? wptr : s1_aw_valid;
                    wstate_d = WBUSY;
                end
            end
            default: begin
                aw_valid    = (wg_q ? s1_aw_valid : s0_aw_valid) && !aw_done_q;
                aw_data     = wg_q ? s1_aw_data : s0_aw_data;
                w_valid     = (wg_q ? s1_w_valid : s0_w_valid) && !w_done_q;
                w_data      = wg_q ? s1_w_data : s0_w_data;
                s0_aw_ready = !wg_q && aw_ready && !aw_done_q;
                s1_aw_ready =  wg_q && aw_ready && !aw_done_q;
                s0_w_ready  = !wg_q && w_ready && !w_done_q;
                s1_w_ready  =  wg_q && w_ready && !w_done_q;
                aw_hs       = aw_valid && aw_ready;
                w_hs        = w_valid && w_ready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = WIDLE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    wptr_d    = ~wg_q;
`endif
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
        endcase
    end

    // Read path: one outstanding read, response steered back to the granted port only.
    always_comb begin
        rstate_d    = rstate_q;
        rg_d        = rg_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        rptr_d      = rptr_q;
`endif
        ar_valid    = 1'b0;
        ar_data     = '0;
        r_ready     = 1'b0;
        s0_ar_ready = 1'b0;
        s1_ar_ready = 1'b0;
        s0_r_valid  = 1'b0;
        s1_r_valid  = 1'b0;
        s0_r_data   = '0;
        s1_r_data   = '0;
        case (rstate_q)
            RIDLE: begin
                if (s0_ar_valid || s1_ar_valid) begin
                    rg_d     = (s0_ar_valid && s1_ar_valid) ? rptr : s1_ar_valid;
                    rstate_d = RADDR;
                end
            end
            RADDR: begin
                ar_valid    = rg_q ? s1_ar_valid : s0_ar_valid;
                ar_data     = rg_q ? s1_ar_data : s0_ar_data;
                s0_ar_ready = !rg_q && ar_ready;
                s1_ar_ready =  rg_q && ar_ready;
                if (ar_valid && ar_ready) rstate_d = RDATA;
            end
            RDATA: begin
                s0_r_valid = !rg_q && r_valid;
                s1_r_valid =  rg_q && r_valid;
                s0_r_data  = rg_q ? '0 : r_data;
                s1_r_data  = rg_q ? r_data : '0;
                r_ready    = rg_q ? s1_r_ready : s0_r_ready;
                if (r_valid && r_ready) begin
                    rstate_d = RIDLE;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                    rptr_d   = ~rg_q;
`endif
                end
            end
            default: rstate_d = RIDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= WIDLE;
            rstate_q  <= RIDLE;
            wg_q      <= 1'b0;
            rg_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
`endif
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            wg_q      <= wg_d;
            rg_q      <= rg_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
`endif
        end
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares one `memory` instance (separate aw/w/ar/r valid-ready channels) between two requesters. Write and read paths are arbitrated independently, each by its own small state machine. Each grant is held until the full transaction completes. Sits between two client blocks and a single `memory #(W, D)`, exposing one slave channel set per requester and one master channel set toward the memory.

## Interface
- `W`, 16, data width
- `D`, 256, memory depth; address width `A = $clog2(D)`
- `clk` input 1 clock, rising edge
- `rst` input 1 reset, asynchronous, active-high
- `s0_aw_data`/`s1_aw_data` input A; `sN_aw_valid` input 1; `sN_aw_ready` output 1: requester N write address
- `sN_w_data` input W; `sN_w_valid` input 1; `sN_w_ready` output 1: requester N write data
- `sN_ar_data` input A; `sN_ar_valid` input 1; `sN_ar_ready` output 1: requester N read address
- `sN_r_data` output W; `sN_r_valid` output 1; `sN_r_ready` input 1: requester N read data
- `aw_data` output A; `aw_valid` output 1; `aw_ready` input 1: to memory
- `w_data` output W; `w_valid` output 1; `w_ready` input 1: to memory
- `ar_data` output A; `ar_valid` output 1; `ar_ready` input 1: to memory
- `r_data` input W; `r_valid` input 1; `r_ready` output 1: from memory

## Operation
- Write FSM states: WIDLE, WBUSY.
  - WIDLE: a write request is `sN_aw_valid`; `sN_w_valid` is not required. On a request, register grant `wg` and go to WBUSY.
  - WBUSY: pass granted aw and w channels through combinationally (valid/data forward, ready backward). Track `aw_done` and `w_done` flags, set on each channel's handshake.
  - When both flags are set (including both in the same cycle), clear the flags, update the priority pointer and return to WIDLE.
- Read FSM states: RIDLE, RADDR, RDATA.
  - RIDLE: a read request is `sN_ar_valid`; register grant `rg` and go to RADDR.
  - RADDR: pass the ar channel through; on `ar_valid && ar_ready`, go to RDATA.
  - RDATA: route `r_data`/`r_valid` to `sN_r_*` of `rg`; `r_ready = sN_r_ready` of `rg`. On the r handshake, update the pointer and go to RIDLE.
  - At most one read is outstanding.
- Non-granted ports: all readies 0 and `sN_r_valid` 0. Master valids are 0 in idle states.
- Write and read FSMs run concurrently and independently. Each has its own priority pointer.
- Arbitration when both ports request: the port selected by the pointer wins. With a single requester, that requester wins regardless of pointer.
- Requester channel order (aw before w, or w before aw) is free. A w presented while the port is not granted stalls with ready=0.

## Timing
- Reset values: every `*_ready` and `*_valid` output is 0; `aw_data`, `w_data`, `ar_data` and `sN_r_data` are 0 when idle. FSMs are in WIDLE/RIDLE, pointers select port 0, and flags are cleared.
- Arbitration latency: 1 cycle. Request seen in an idle state → grant registered at the edge → passthrough starts the next cycle.
- Minimum write: 2 cycles (arbitrate, then aw+w handshake together); 3 cycles if aw and w complete in separate cycles.
- Minimum read: arbitrate + ar handshake + memory read latency + r handshake.
- Back-to-back: the idle state re-arbitrates on the cycle after completion. A continuously requesting port therefore sees one idle cycle between grants.
- `rst` asserted mid-transaction clears all state immediately. In-flight transfers are abandoned and handshake outputs drop to 0 asynchronously.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN` defined: on each completed transaction, that path's pointer moves to the other port from the one just served.
- Undefined: fixed priority. The pointer is constant 0 and port 0 always wins a simultaneous request; pointer registers are not built.

## Test plan
- Single write/read: s0 writes 0xBEEF to address 0x12, then reads 0x12 → `s0_r_data` = 0xBEEF. s1 sees no ready or valid throughout.
- Concurrent writes, round-robin: both ports hold aw/w valid continuously, 4 writes each to distinct addresses → grants alternate s0,s1,s0,… and all 8 read back correctly. Without the macro, all s0 writes complete before any s1 write.
- Split write: s1 presents aw=0x40, then w=0x1234 five cycles later → grant held in WBUSY until w completes. An s0 request during this time waits. Readback of 0x40 = 0x1234.
- Read routing with backpressure: s0 and s1 read addresses holding 0xAAAA and 0x5555. Each requester's `r_ready` is held low for 3 cycles → every response reaches only the issuing port with correct data, and the second ar waits for the first r handshake.
- Concurrent read and write: s0 writes while s1 reads a different address in the same cycles → both complete with no interaction, and the write FSM and read FSM are granted in parallel.
- Reset mid-transaction: assert `rst` while in WBUSY with `aw_done`=1 → all outputs 0 immediately. After release, s1 write 0x0F0F to 0x03 succeeds with the pointer back at port 0.
